// File: rtl/general_reg_file_pkg.sv
// ============================================================================
// general_reg_file_pkg : shared constants for the general-purpose register file
// Revision: 1.0
// ============================================================================
`default_nettype none

package general_reg_file_pkg;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

`default_nettype wire

// File: rtl/general_reg_file.sv
// ============================================================================
// general_reg_file : 2-read / 1-write register file, register 0 hardwired zero
// Revision: 1.0
// ============================================================================
`default_nettype none

module general_reg_file
  import general_reg_file_pkg::*;
#(
  parameter int DATA_W = general_reg_file_pkg::DATA_W,
  parameter int NREGS  = general_reg_file_pkg::NREGS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(NREGS)-1:0]   A1,
  input  logic [$clog2(NREGS)-1:0]   A2,
  input  logic [$clog2(NREGS)-1:0]   A3,
  input  logic [DATA_W-1:0]          WD,
  input  logic                       WE,
  output logic [DATA_W-1:0]          RD1,
  output logic [DATA_W-1:0]          RD2
);

  localparam int AW = $clog2(NREGS);

  // Read view of the file; entry 0 is a constant so it never gets a flop.
  logic [DATA_W-1:0] rf_view [NREGS];

  assign rf_view[ZERO_REG] = '0;

  for (genvar i = 1; i < NREGS; i++) begin : g_reg
    logic [DATA_W-1:0] reg_q;
    logic [DATA_W-1:0] reg_d;
    logic              wr_en;

    assign wr_en = WE && (A3 == AW'(i));
    assign reg_d = wr_en ? WD : reg_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        reg_q <= '0;
      end else begin
        reg_q <= reg_d;
      end
    end

    assign rf_view[i] = reg_q;
  end

  // No write bypass: a same-address read shows the old value until the edge.
  assign RD1 = rf_view[A1];
  assign RD2 = rf_view[A2];

endmodule

`default_nettype wire

// File: tb/tb_general_reg_file.sv
// ============================================================================
// tb_general_reg_file : directed self-checking bench for general_reg_file
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_general_reg_file;

  logic        clk;
  logic        reset;
  logic [4:0]  A1, A2, A3;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD1, RD2;

  int tests_run;
  int tests_failed;

  general_reg_file #(.DATA_W(32), .NREGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .A1    (A1),
    .A2    (A2),
    .A3    (A3),
    .WD    (WD),
    .WE    (WE),
    .RD1   (RD1),
    .RD2   (RD2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    WE = 1'b1;
    A3 = addr;
    WD = data;
    tick();
    WE = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i);
      A2 = 5'(31 - i);
      #1;
      tests_run++;
      if (RD1 !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_rd1 addr=%0d actual=%h required=%h", i, RD1, 32'h0);
      end
      tests_run++;
      if (RD2 !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_rd2 addr=%0d actual=%h required=%h", 31 - i, RD2, 32'h0);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_write();
    do_write(5'd5, 32'h12345678);
    A1 = 5'd5;
    A2 = 5'd5;
    #1;
    tests_run++;
    if (RD1 !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL basic_write_rd1 actual=%h required=%h", RD1, 32'h12345678);
    end
    tests_run++;
    if (RD2 !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL basic_write_rd2 actual=%h required=%h", RD2, 32'h12345678);
    end
  endtask

  task automatic test_zero_reg();
    do_write(5'd0, 32'hFFFFFFFF);
    A1 = 5'd0;
    A2 = 5'd5;
    #1;
    tests_run++;
    if (RD1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL zero_reg actual=%h required=%h", RD1, 32'h0);
    end
    tests_run++;
    if (RD2 !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL zero_reg_side_effect actual=%h required=%h", RD2, 32'h12345678);
    end
  endtask

  task automatic test_same_cycle();
    do_write(5'd7, 32'hA);
    A1 = 5'd7;
    A2 = 5'd7;
    A3 = 5'd7;
    WD = 32'hB;
    WE = 1'b1;
    #1;
    tests_run++;
    if (RD1 !== 32'hA) begin
      tests_failed++;
      $display("FAIL same_cycle_before actual=%h required=%h", RD1, 32'hA);
    end
    tick();
    WE = 1'b0;
    tests_run++;
    if (RD1 !== 32'hB) begin
      tests_failed++;
      $display("FAIL same_cycle_after_rd1 actual=%h required=%h", RD1, 32'hB);
    end
    tests_run++;
    if (RD2 !== 32'hB) begin
      tests_failed++;
      $display("FAIL same_cycle_after_rd2 actual=%h required=%h", RD2, 32'hB);
    end
  endtask

  task automatic test_we_low();
    do_write(5'd3, 32'h3);
    WE = 1'b0;
    A3 = 5'd3;
    WD = 32'hDEAD;
    tick();
    tick();
    A1 = 5'd3;
    #1;
    tests_run++;
    if (RD1 !== 32'h3) begin
      tests_failed++;
      $display("FAIL we_low actual=%h required=%h", RD1, 32'h3);
    end
  endtask

  task automatic test_fill_all();
    for (int i = 1; i < 32; i++) begin
      do_write(5'(i), 32'(i));
    end
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i);
      A2 = 5'(31 - i);
      #1;
      tests_run++;
      if (RD1 !== 32'(i)) begin
        tests_failed++;
        $display("FAIL fill_rd1 addr=%0d actual=%h required=%h", i, RD1, 32'(i));
      end
      tests_run++;
      if (RD2 !== 32'(31 - i)) begin
        tests_failed++;
        $display("FAIL fill_rd2 addr=%0d actual=%h required=%h", 31 - i, RD2, 32'(31 - i));
      end
    end
  endtask

  task automatic test_async_reset();
    do_write(5'd9, 32'h55);
    A1 = 5'd9;
    A2 = 5'd10;
    #1;
    tests_run++;
    if (RD1 !== 32'h55) begin
      tests_failed++;
      $display("FAIL async_pre actual=%h required=%h", RD1, 32'h55);
    end
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if (RD1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL async_clear_reg9 actual=%h required=%h", RD1, 32'h0);
    end
    tests_run++;
    if (RD2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL async_clear_reg10 actual=%h required=%h", RD2, 32'h0);
    end
    WE = 1'b1;
    A3 = 5'd9;
    WD = 32'h77;
    tick();
    tests_run++;
    if (RD1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL write_during_reset actual=%h required=%h", RD1, 32'h0);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (RD1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL release_no_write actual=%h required=%h", RD1, 32'h0);
    end
    tick();
    WE = 1'b0;
    tests_run++;
    if (RD1 !== 32'h77) begin
      tests_failed++;
      $display("FAIL write_after_release actual=%h required=%h", RD1, 32'h77);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b1;
    WE    = 1'b0;
    A1    = '0;
    A2    = '0;
    A3    = '0;
    WD    = '0;

    test_reset();
    test_basic_write();
    test_zero_reg();
    test_same_cycle();
    test_we_low();
    test_fill_all();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
